// File: rtl/bus_dma.sv
// bus_dma: byte-wide block-copy engine sharing the memory bus via request/grant.
// Optional fill mode (constant byte stored to a range) enabled by macro BUS_DMA_FILL_EN.
module bus_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [23:0]          src_address,
  input  logic [23:0]          dst_address,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 fill,
  input  logic [7:0]           fill_value,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_request,
  input  logic                 bus_grant,
  output logic [23:0]          address,
  output logic [7:0]           data_out,
  input  logic [7:0]           data_in,
  output logic                 bus_enable,
  output logic                 write_enable,
  input  logic                 bus_halt
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_WAIT,
    READ_ADDR,
    READ_DATA,
    WRITE,
    DONE
  } state_t;

  state_t               state_q;
  logic [23:0]          src_q;
  logic [23:0]          dst_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [7:0]           byte_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 req_q;

  logic [23:0]          src_d;
  logic [23:0]          dst_d;
  logic [LEN_WIDTH-1:0] rem_d;
  logic                 fill_mode;
  logic [7:0]           wdata;

  assign src_d = src_q + 24'd1;
  assign dst_d = dst_q + 24'd1;
  assign rem_d = rem_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};

`ifdef BUS_DMA_FILL_EN
  logic       fill_q;
  logic [7:0] fval_q;

  assign fill_mode = fill_q;
  assign wdata     = fill_q ? fval_q : byte_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill, fill_value};
  assign fill_mode   = 1'b0;
  assign wdata       = byte_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus_request = req_q;

  // Transfer sequencer: state, address/length counters and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
`ifdef BUS_DMA_FILL_EN
      fill_q  <= 1'b0;
      fval_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q  <= src_address;
            dst_q  <= dst_address;
            rem_q  <= length;
            busy_q <= 1'b1;
`ifdef BUS_DMA_FILL_EN
            fill_q <= fill;
            fval_q <= fill_value;
`endif
            if (length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= GRANT_WAIT;
              req_q   <= 1'b1;
            end
          end
        end
        GRANT_WAIT: begin
          if (bus_grant) begin
            state_q <= fill_mode ? WRITE : READ_ADDR;
          end
        end
        READ_ADDR: begin
          state_q <= READ_DATA;
        end
        READ_DATA: begin
          if (!bus_halt) begin
            byte_q  <= data_in;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (!bus_halt) begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_d;
            if (rem_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state_q <= fill_mode ? WRITE : READ_ADDR;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Bus strobes follow the state; everything is zero outside bus states
  always_comb begin
    address      = '0;
    data_out     = '0;
    bus_enable   = 1'b0;
    write_enable = 1'b0;
    unique case (state_q)
      READ_ADDR, READ_DATA: begin
        address    = src_q;
        bus_enable = 1'b1;
      end
      WRITE: begin
        address      = dst_q;
        data_out     = wdata;
        bus_enable   = 1'b1;
        write_enable = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: directed scoreboard bench for bus_dma with a negedge bus slave model.
// Expected writes are queued by stimulus and popped by the slave monitor.
module tb_bus_dma;

  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [23:0]   src_address;
  logic [23:0]   dst_address;
  logic [LW-1:0] length;
  logic          fill;
  logic [7:0]    fill_value;
  logic          busy;
  logic          done;
  logic          bus_request;
  logic          bus_grant;
  logic [23:0]   address;
  logic [7:0]    data_out;
  logic [7:0]    data_in;
  logic          bus_enable;
  logic          write_enable;
  logic          bus_halt;

  bus_dma #(.LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_address  (src_address),
    .dst_address  (dst_address),
    .length       (length),
    .fill         (fill),
    .fill_value   (fill_value),
    .busy         (busy),
    .done         (done),
    .bus_request  (bus_request),
    .bus_grant    (bus_grant),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in),
    .bus_enable   (bus_enable),
    .write_enable (write_enable),
    .bus_halt     (bus_halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [int];
  wr_t         exp_q [$];
  logic [23:0] rd_log [$];

  int n_cmp = 0;
  int n_bad = 0;

  int busy_cnt = 0;
  int done_cnt = 0;
  int req_seen = 0;
  int en_seen = 0;
  int nogrant_strobe = 0;
  int halt_left = 0;
  int halt_bad = 0;
  int halt_cyc = 0;
  int gdelay_left = 0;
  logic [23:0] halt_addr = '0;
  bit prev_rd = 0;
  bit halt_prev = 0;
  bit sb_en = 1;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void push_wr(input logic [23:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  // Bus slave, arbiter and monitor: all act on the falling edge
  always @(negedge clk) begin
    bit  rd;
    wr_t e;
    if (bus_enable && !bus_grant) nogrant_strobe++;
    if (bus_request) begin
      if (gdelay_left > 0) begin
        bus_grant = 1'b0;
        gdelay_left--;
      end else begin
        bus_grant = 1'b1;
      end
    end else begin
      bus_grant = 1'b0;
    end
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (bus_request) req_seen++;
    if (bus_enable) en_seen++;
    rd = bus_enable && !write_enable;
    if (rd && !prev_rd) rd_log.push_back(address);
    prev_rd = rd;
    if (halt_prev) begin
      if (!(rd && address === halt_addr)) halt_bad++;
    end
    if (rd && halt_left > 0) begin
      bus_halt = 1'b1;
      halt_left--;
      halt_cyc++;
    end else begin
      bus_halt = 1'b0;
    end
    halt_prev = bus_halt;
    if (rd) data_in = mem.exists(int'(address)) ? mem[int'(address)] : 8'h00;
    if (bus_enable && write_enable && !bus_halt) begin
      mem[int'(address)] = data_out;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got %0h@%0h expected none",
                   data_out, address);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {8'h0, address}, {8'h0, e.a});
          chk("wr_data", {24'h0, data_out}, {24'h0, e.d});
        end
      end
    end
  end

  task automatic run(input logic [23:0] s, input logic [23:0] d,
                     input logic [LW-1:0] len, input bit f,
                     input logic [7:0] fv, input int gdel, input int hl,
                     input int poke, output int lat);
    busy_cnt = 0;
    done_cnt = 0;
    req_seen = 0;
    en_seen = 0;
    nogrant_strobe = 0;
    halt_bad = 0;
    halt_cyc = 0;
    rd_log.delete();
    @(negedge clk);
    gdelay_left = gdel;
    halt_left = hl;
    halt_addr = s;
    src_address = s;
    dst_address = d;
    length = len;
    fill = f;
    fill_value = fv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        lat = i + 1;
        break;
      end
      if (i == poke) begin
        start = 1'b1;
        length = 16'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done expected done within 300 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  seen;
    reset = 1'b1;
    start = 1'b0;
    src_address = '0;
    dst_address = '0;
    length = '0;
    fill = 1'b0;
    fill_value = '0;
    bus_grant = 1'b0;
    bus_halt = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_address", {8'h0, address}, 32'h0);
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    chk("rst_bus_enable", {31'h0, bus_enable}, 32'h0);
    chk("rst_write_enable", {31'h0, write_enable}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_bus_request", {31'h0, bus_request}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mem[32'h4010] = 8'h11;
    mem[32'h4011] = 8'h22;
    mem[32'h4012] = 8'h33;
    mem[32'h4013] = 8'h44;
    push_wr(24'h000100, 8'h11);
    push_wr(24'h000101, 8'h22);
    push_wr(24'h000102, 8'h33);
    push_wr(24'h000103, 8'h44);
    run(24'h004010, 24'h000100, 16'd4, 1'b0, 8'h00, 0, 0, -1, lat);
    chk("copy4_busy", busy_cnt, 14);
    chk("copy4_done_cnt", done_cnt, 1);
    chk("copy4_latency", lat, 14);
    chk("copy4_queue_left", exp_q.size(), 0);
    chk("copy4_ram0", {24'h0, mem[32'h100]}, 32'h11);
    chk("copy4_ram3", {24'h0, mem[32'h103]}, 32'h44);

    run(24'h004010, 24'h000500, 16'd0, 1'b0, 8'h00, 0, 0, -1, lat);
    chk("len0_latency", lat, 1);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_busy", busy_cnt, 1);
    chk("len0_req_seen", req_seen, 0);
    chk("len0_en_seen", en_seen, 0);

    mem[32'h10000] = 8'h77;
    push_wr(24'h000120, 8'h77);
    run(24'h010000, 24'h000120, 16'd1, 1'b0, 8'h00, 0, 21, -1, lat);
    chk("halt_cycles", halt_cyc, 21);
    chk("halt_addr_stable", halt_bad, 0);
    chk("halt_busy", busy_cnt, 25);
    chk("halt_queue_left", exp_q.size(), 0);
    chk("halt_ram", {24'h0, mem[32'h120]}, 32'h77);

    mem[32'hFFFFFF] = 8'h5A;
    mem[32'h0] = 8'h6B;
    push_wr(24'h000300, 8'h5A);
    push_wr(24'h000301, 8'h6B);
    run(24'hFFFFFF, 24'h000300, 16'd2, 1'b0, 8'h00, 0, 0, -1, lat);
    chk("wrap_reads", rd_log.size(), 2);
    chk("wrap_rd0", rd_log.size() > 0 ? {8'h0, rd_log[0]} : 32'hFFFF_FFFF,
        32'h00FF_FFFF);
    chk("wrap_rd1", rd_log.size() > 1 ? {8'h0, rd_log[1]} : 32'hFFFF_FFFF,
        32'h0);
    chk("wrap_queue_left", exp_q.size(), 0);

    mem[32'h4020] = 8'h99;
    push_wr(24'h000140, 8'h99);
    run(24'h004020, 24'h000140, 16'd1, 1'b0, 8'h00, 10, 0, 3, lat);
    chk("grant_busy", busy_cnt, 15);
    chk("grant_latency", lat, 15);
    chk("grant_nogrant_strobe", nogrant_strobe, 0);
    chk("grant_en_seen", en_seen, 3);
    chk("grant_queue_left", exp_q.size(), 0);
    length = '0;

    sb_en = 0;
    done_cnt = 0;
    @(negedge clk);
    src_address = 24'h004010;
    dst_address = 24'h000180;
    length = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (write_enable) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_mid_write_seen", {31'h0, seen}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_mid_address", {8'h0, address}, 32'h0);
    chk("rst_mid_bus_enable", {31'h0, bus_enable}, 32'h0);
    chk("rst_mid_write_enable", {31'h0, write_enable}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_bus_request", {31'h0, bus_request}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, 0);
    exp_q.delete();
    sb_en = 1;

`ifdef BUS_DMA_FILL_EN
    push_wr(24'h000200, 8'hA5);
    push_wr(24'h000201, 8'hA5);
    push_wr(24'h000202, 8'hA5);
    run(24'h004010, 24'h000200, 16'd3, 1'b1, 8'hA5, 0, 0, -1, lat);
    chk("fill_reads", rd_log.size(), 0);
    chk("fill_busy", busy_cnt, 5);
    chk("fill_en_seen", en_seen, 3);
    chk("fill_ram2", {24'h0, mem[32'h202]}, 32'hA5);
`else
    push_wr(24'h000200, 8'h11);
    push_wr(24'h000201, 8'h22);
    push_wr(24'h000202, 8'h33);
    run(24'h004010, 24'h000200, 16'd3, 1'b1, 8'hA5, 0, 0, -1, lat);
    chk("fill_off_reads", rd_log.size(), 3);
    chk("fill_off_busy", busy_cnt, 11);
    chk("fill_off_en_seen", en_seen, 9);
    chk("fill_off_ram2", {24'h0, mem[32'h202]}, 32'h33);
`endif
    chk("fill_queue_left", exp_q.size(), 0);
    chk("fill_done_cnt", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_dma.md
Name: bus_dma

Overview:
- Byte-wide block-copy engine that acts as a second initiator on the memory bus; it shares the bus with the CPU through a request/grant pair.
- Firmware loads the source, destination and length, then pulses start.
- The engine copies bytes by issuing reads and writes with the same address/data/enable/write-enable/halt signalling the CPU uses.
- Typical use: copying code or data out of SPI flash (upper pages, bank 3) into RAM (bank 0) without CPU byte loops.

Parameters:
LEN_WIDTH, 16, width of transfer length counter (max transfer 2^LEN_WIDTH-1 bytes)

Ports:
clk  input  1  system clock (same clock as CPU/memory bus clk)
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begin transfer when idle
src_address  input  24  first source byte address, sampled on start
dst_address  input  24  first destination byte address, sampled on start
length  input  LEN_WIDTH  byte count, sampled on start
fill  input  1  fill mode select, sampled on start (see Optional Feature)
fill_value  input  8  fill byte, sampled on start
busy  output  1  high from cycle after accepted start through DONE cycle
done  output  1  one-cycle pulse when transfer completes
bus_request  output  1  high while engine wants the bus
bus_grant  input  1  arbiter grant; engine drives bus only when high
address  output  24  bus address
data_out  output  8  write data to bus data_in
data_in  input  8  read data from bus data_out
bus_enable  output  1  bus access strobe
write_enable  output  1  bus write strobe
bus_halt  input  1  slave not ready; hold current access

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, bus_request=0, bus_enable=0, write_enable=0, address=0, data_out=0; internal counters cleared. Reset mid-transfer abandons the transfer immediately; no completion pulse.
- States: IDLE, GRANT_WAIT, READ_ADDR, READ_DATA, WRITE, DONE.
- IDLE:
  - On start, capture src/dst/length/fill/fill_value.
  - length==0 -> DONE directly; no bus cycle, no bus_request.
  - length!=0 -> GRANT_WAIT.
  - start while not IDLE is ignored.
- GRANT_WAIT: bus_request=1, bus outputs inactive. When bus_grant=1 -> READ_ADDR (fill mode -> WRITE).
- READ_ADDR: one cycle; address=src, bus_enable=1, write_enable=0 -> READ_DATA.
- READ_DATA:
  - address=src, bus_enable=1.
  - bus_halt=1: stay.
  - bus_halt=0: latch data_in into byte register -> WRITE.
- WRITE:
  - address=dst, data_out=byte register (or fill_value), bus_enable=1, write_enable=1.
  - bus_halt=1: stay, outputs held.
  - bus_halt=0: src+=1, dst+=1, remaining-=1.
  - remaining reaches 0 -> DONE; otherwise next byte (READ_ADDR, or WRITE in fill mode).
- Address increment is modulo 2^24 (0xFFFFFF -> 0x000000).
- bus_request is held high from GRANT_WAIT through the last WRITE. bus_grant is sampled only in GRANT_WAIT; the arbiter must not revoke the grant while bus_request=1.
- DONE: done=1 for exactly one cycle, bus_request=0, all strobes 0 -> IDLE.
- busy=1 in every state except IDLE.
- Throughput with no halt: 3 cycles/byte in copy mode, 1 cycle/byte in fill mode, plus 1 DONE cycle and the grant latency.
- Bus outputs (address, data_out, bus_enable, write_enable) are combinational from state and registers, and are 0 when not in READ_ADDR/READ_DATA/WRITE.

Optional Feature:
- Macro BUS_DMA_FILL_EN.
- Defined: fill=1 at start selects fill mode. Reads are skipped; each WRITE stores the captured fill_value to successive dst addresses.
- Undefined: fill and fill_value are ignored; every transfer is a copy. No fill logic is synthesized.

Test Plan:
- Copy 4 bytes src=0x004010 (ROM 11,22,33,44) to dst=0x000100, grant immediate, no halt -> RAM 0x100..0x103 = 11,22,33,44; busy high 14 cycles; one done pulse.
- length=0 start -> done pulses on the cycle after start, bus_request and bus_enable never asserted.
- Source in flash (0x010000), bus_halt held high 20 cycles in READ_DATA -> address/bus_enable held stable throughout; correct byte written after halt drops.
- src=0xFFFFFF, length=2 -> second read at address 0x000000.
- bus_grant withheld 10 cycles -> no bus strobes until grant; start pulse during busy ignored (length unchanged); reset asserted mid-WRITE -> all outputs 0 next sample, no done.
- With BUS_DMA_FILL_EN, fill=1, fill_value=0xA5, length=3, dst=0x000200 -> 3 consecutive write cycles, RAM = A5,A5,A5, no read strobes; without macro the same stimulus performs a copy.
